// File: rtl/hpu_axil_master_if.sv
// AXI4-Lite channel bundle between the HPU command master and a register-file slave.
interface hpu_axil_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hpu_axil_master.sv
// Single-outstanding AXI4-Lite master: turns a local command/response handshake into
// AW/W/B or AR/R transactions and counts SLVERR/DECERR responses.
module hpu_axil_master #(
  parameter int ADDR_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt,
  hpu_axil_master_if.master m_axi
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RR, RSP} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t state, next_state;
  logic   aw_done, w_done;
  logic   aw_fin, w_fin;
  logic   b_take, r_take, resp_err;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A channel counts as finished in the very cycle its handshake happens.
  always_comb begin
    next_state = state;
    aw_fin     = aw_done | (m_axi.awvalid & m_axi.awready);
    w_fin      = w_done  | (m_axi.wvalid  & m_axi.wready);
    b_take     = (state == WB) & m_axi.bvalid;
    r_take     = (state == RR) & m_axi.rvalid;
    resp_err   = (b_take & m_axi.bresp[1]) | (r_take & m_axi.rresp[1]);
    case (state)
      IDLE: if (cmd_valid) next_state = cmd_write ? WR : RA;
      WR:   if (aw_fin && w_fin) next_state = WB;
      WB:   if (m_axi.bvalid) next_state = RSP;
      RA:   if (m_axi.arready) next_state = RR;
      RR:   if (m_axi.rvalid) next_state = RSP;
      RSP:  if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_write) begin
            m_axi.awaddr  <= cmd_addr & ALIGN_MASK;
            m_axi.wdata   <= cmd_wdata;
            m_axi.wstrb   <= cmd_wstrb;
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end else if (cmd_valid) begin
            m_axi.araddr  <= cmd_addr & ALIGN_MASK;
            m_axi.arvalid <= 1'b1;
          end
        end
        WR: begin
          if (m_axi.awvalid && m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (m_axi.wvalid && m_axi.wready) begin
            m_axi.wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) m_axi.bready <= 1'b1;
        end
        WB: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi.bresp;
          end
        end
        RA: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
          end
        end
        RR: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_rdata    <= m_axi.rdata;
            rsp_resp     <= m_axi.rresp;
          end
        end
        RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        err_cnt <= '0;
    else if (resp_err && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hpu_axil_master.sv
// Scoreboard bench for hpu_axil_master with a behavioural AXI-Lite slave whose
// per-channel ready delays and response codes are set by each test.
module tb_hpu_axil_master;
  localparam int ADDR_W = 32;
  localparam int ERR_W  = 8;

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              busy;
  logic [ERR_W-1:0]  err_cnt;

  hpu_axil_master_if #(.ADDR_W(ADDR_W)) axi ();

  hpu_axil_master #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .err_cnt(err_cnt),
    .m_axi(axi)
  );

  initial forever #5 clk = ~clk;

  rsp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          aw_tot = 0, w_tot = 0, b_tot = 0, ar_tot = 0, r_tot = 0;

  // Slave decides its outputs on the falling edge; a handshake is known the moment both sides are high.
  initial begin
    int   aw_cnt, w_cnt, ar_cnt;
    bit   aw_got, w_got, b_pend, r_pend;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        continue;
      end
      axi.bvalid = b_pend;
      axi.bresp  = b_pend ? bresp_cfg : 2'b00;
      if (axi.bvalid && axi.bready) begin b_tot++; b_pend = 0; end
      axi.rvalid = r_pend;
      axi.rdata  = r_pend ? rdata_cfg : 32'h0;
      axi.rresp  = r_pend ? rresp_cfg : 2'b00;
      if (axi.rvalid && axi.rready) begin r_tot++; r_pend = 0; end
      if (!axi.awvalid) begin aw_cnt = 0; axi.awready = 0; end
      else begin axi.awready = (aw_cnt >= aw_delay); aw_cnt++; end
      if (axi.awvalid && axi.awready) begin aw_tot++; aw_got = 1; end
      if (!axi.wvalid) begin w_cnt = 0; axi.wready = 0; end
      else begin axi.wready = (w_cnt >= w_delay); w_cnt++; end
      if (axi.wvalid && axi.wready) begin w_tot++; w_got = 1; end
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (!axi.arvalid) begin ar_cnt = 0; axi.arready = 0; end
      else begin axi.arready = (ar_cnt >= ar_delay); ar_cnt++; end
      if (axi.arvalid && axi.arready) begin ar_tot++; r_pend = 1; end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rsp_t mk_rsp(input logic w, input logic [31:0] d, input logic [1:0] r);
    rsp_t x;
    x.write = w; x.rdata = d; x.resp = r;
    return x;
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input rsp_t exp, output bit ok);
    exp_q.push_back(exp);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output bit found, output int waits);
    found = 0; waits = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin found = 1; break; end
      @(negedge clk);
      waits++;
    end
  endtask

  task automatic accept_rsp(output rsp_t got);
    got = mk_rsp(rsp_write, rsp_rdata, rsp_resp);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_valids: got %b expected 00000",
                        {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
    end
    tests++;
    if ({axi.awaddr, axi.araddr, axi.wdata, axi.wstrb} !== '0) begin
      fails++; $display("[TB] FAIL reset_payload: got %h/%h/%h/%h expected all 0",
                        axi.awaddr, axi.araddr, axi.wdata, axi.wstrb);
    end
    tests++;
    if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_cnt} !== '0) begin
      fails++; $display("[TB] FAIL reset_rsp: got v=%b w=%b d=%h r=%b e=%h expected all 0",
                        rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_cnt);
    end
    tests++;
    if ({cmd_ready, busy} !== 2'b10) begin
      fails++; $display("[TB] FAIL reset_idle: got ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
  endtask

  task automatic test_write_basic;
    bit ok, found; int waits; rsp_t got, exp;
    aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00;
    send_cmd(1'b1, 32'h000, 32'h3, 4'hF, mk_rsp(1'b1, 32'h0, 2'b00), ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL wr_accept: got no accept expected accept"); end
    tests++;
    if ({axi.awvalid, axi.wvalid, busy, axi.awaddr, axi.wdata, axi.wstrb} !== {3'b111, 32'h0, 32'h3, 4'hF}) begin
      fails++; $display("[TB] FAIL wr_t1: got aw=%b w=%b busy=%b addr=%h data=%h strb=%h expected 1/1/1/0/3/f",
                        axi.awvalid, axi.wvalid, busy, axi.awaddr, axi.wdata, axi.wstrb);
    end
    wait_rsp(found, waits);
    tests++;
    if (!found || waits != 2) begin
      fails++; $display("[TB] FAIL wr_latency: got found=%0d waits=%0d expected 1/2", found, waits);
    end
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp || err_cnt !== 8'd0) begin
      fails++; $display("[TB] FAIL wr_rsp: got %h err=%h expected %h err=00", got, err_cnt, exp);
    end
  endtask

  task automatic test_write_skew;
    bit ok, found; int waits, b0, aw0; rsp_t got, exp;
    aw_delay = 2; w_delay = 0; bresp_cfg = 2'b00;
    b0 = b_tot; aw0 = aw_tot;
    send_cmd(1'b1, 32'h013, 32'hDEADBEEF, 4'hF, mk_rsp(1'b1, 32'h0, 2'b00), ok);
    tests++;
    if (!ok || axi.awaddr !== 32'h010 || axi.wdata !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL skew_addr: got ok=%0d addr=%h data=%h expected 1/010/deadbeef",
                        ok, axi.awaddr, axi.wdata);
    end
    @(negedge clk);
    tests++;
    if ({axi.awvalid, axi.wvalid} !== 2'b10) begin
      fails++; $display("[TB] FAIL skew_wdrop: got aw,w=%b expected 10", {axi.awvalid, axi.wvalid});
    end
    @(negedge clk);
    tests++;
    if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin
      fails++; $display("[TB] FAIL skew_awhold: got aw,w,b=%b expected 100", {axi.awvalid, axi.wvalid, axi.bready});
    end
    wait_rsp(found, waits);
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (!found || got !== exp) begin
      fails++; $display("[TB] FAIL skew_rsp: got found=%0d %h expected %h", found, got, exp);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (b_tot - b0 != 1 || aw_tot - aw0 != 1) begin
      fails++; $display("[TB] FAIL skew_counts: got b=%0d aw=%0d expected 1/1", b_tot - b0, aw_tot - aw0);
    end
    aw_delay = 0;
  endtask

  task automatic test_read_delay;
    bit ok, found; int waits, held; rsp_t got, exp;
    ar_delay = 3; rdata_cfg = 32'h00000006; rresp_cfg = 2'b00;
    send_cmd(1'b0, 32'h000, 32'h0, 4'h0, mk_rsp(1'b0, 32'h6, 2'b00), ok);
    tests++;
    if (!ok || axi.araddr !== 32'h0) begin
      fails++; $display("[TB] FAIL rd_addr: got ok=%0d addr=%h expected 1/0", ok, axi.araddr);
    end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (!axi.arvalid) break;
      held++;
      @(negedge clk);
    end
    tests++;
    if (held != 4) begin fails++; $display("[TB] FAIL rd_arhold: got %0d cycles expected 4", held); end
    wait_rsp(found, waits);
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (!found || got !== exp) begin
      fails++; $display("[TB] FAIL rd_rsp: got found=%0d %h expected %h", found, got, exp);
    end
    ar_delay = 0;
  endtask

  task automatic test_rsp_stall;
    bit ok, found; int waits, bad, aw0, ar0; rsp_t got, exp;
    rdata_cfg = 32'hA5A51234; rresp_cfg = 2'b00;
    send_cmd(1'b0, 32'h010, 32'h0, 4'h0, mk_rsp(1'b0, 32'hA5A51234, 2'b00), ok);
    wait_rsp(found, waits);
    exp = exp_q.pop_front();
    tests++;
    if (!ok || !found) begin fails++; $display("[TB] FAIL stall_rsp: got ok=%0d found=%0d expected 1/1", ok, found); end
    aw0 = aw_tot; ar0 = ar_tot;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'h7; cmd_wstrb = 4'hF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp} !== {1'b1, exp} || cmd_ready !== 1'b0 ||
          {axi.awvalid, axi.wvalid, axi.arvalid} !== 3'b000) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("[TB] FAIL stall_hold: got %0d bad cycles (v=%b d=%h ready=%b) expected 0",
                        bad, rsp_valid, rsp_rdata, cmd_ready);
    end
    exp_q.push_back(mk_rsp(1'b1, 32'h0, 2'b00));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    tests++;
    if ({cmd_ready, rsp_valid} !== 2'b10 || aw_tot != aw0 || ar_tot != ar0) begin
      fails++; $display("[TB] FAIL stall_release: got ready=%b v=%b traffic=%0d expected 1/0/0",
                        cmd_ready, rsp_valid, (aw_tot - aw0) + (ar_tot - ar0));
    end
    @(negedge clk);
    cmd_valid = 0;
    tests++;
    if (axi.awvalid !== 1'b1) begin fails++; $display("[TB] FAIL stall_next: got awvalid=%b expected 1", axi.awvalid); end
    wait_rsp(found, waits);
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (!found || got !== exp) begin
      fails++; $display("[TB] FAIL stall_next_rsp: got found=%0d %h expected %h", found, got, exp);
    end
  endtask

  task automatic test_error_saturate;
    bit ok, found; int waits, bad; rsp_t got, exp; logic [ERR_W-1:0] exp_err;
    rresp_cfg = 2'b01; rdata_cfg = 32'h1;
    send_cmd(1'b0, 32'h000, 32'h0, 4'h0, mk_rsp(1'b0, 32'h1, 2'b01), ok);
    wait_rsp(found, waits);
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (!found || got !== exp || err_cnt !== 8'd0) begin
      fails++; $display("[TB] FAIL err_okay: got %h err=%h expected %h err=00", got, err_cnt, exp);
    end
    bresp_cfg = 2'b11;
    send_cmd(1'b1, 32'h010, 32'h1, 4'hF, mk_rsp(1'b1, 32'h0, 2'b11), ok);
    wait_rsp(found, waits);
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (!found || got !== exp || err_cnt !== 8'd1) begin
      fails++; $display("[TB] FAIL err_decerr: got %h err=%h expected %h err=01", got, err_cnt, exp);
    end
    bresp_cfg = 2'b00; rresp_cfg = 2'b10; rdata_cfg = 32'h0;
    exp_err = 8'd1; bad = 0;
    for (int i = 0; i < 256; i++) begin
      send_cmd(1'b0, 32'h000, 32'h0, 4'h0, mk_rsp(1'b0, 32'h0, 2'b10), ok);
      wait_rsp(found, waits);
      accept_rsp(got);
      exp = exp_q.pop_front();
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      if (!found || got !== exp || err_cnt !== exp_err) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("[TB] FAIL err_sequence: got %0d bad reads expected 0", bad); end
    tests++;
    if (err_cnt !== 8'hFF) begin fails++; $display("[TB] FAIL err_saturate: got %h expected ff", err_cnt); end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid;
    bit ok, found, seen; int waits, b0; rsp_t got, exp;
    aw_delay = 5; w_delay = 5;
    send_cmd(1'b1, 32'h010, 32'h1, 4'hF, mk_rsp(1'b1, 32'h0, 2'b00), ok);
    tests++;
    if (!ok || axi.awvalid !== 1'b1) begin fails++; $display("[TB] FAIL mid_pre: got ok=%0d aw=%b expected 1/1", ok, axi.awvalid); end
    #2 rst = 1;
    #1;
    tests++;
    if ({axi.awvalid, axi.wvalid, axi.bready, busy, rsp_valid, cmd_ready} !== 6'b000001) begin
      fails++; $display("[TB] FAIL mid_async: got aw,w,b,busy,v,ready=%b expected 000001",
                        {axi.awvalid, axi.wvalid, axi.bready, busy, rsp_valid, cmd_ready});
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    aw_delay = 0; w_delay = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1;
    end
    tests++;
    if (seen || err_cnt !== 8'd0) begin fails++; $display("[TB] FAIL mid_quiet: got activity=%0d err=%h expected 0/00", seen, err_cnt); end
    b0 = b_tot;
    send_cmd(1'b1, 32'h000, 32'h2, 4'h3, mk_rsp(1'b1, 32'h0, 2'b00), ok);
    wait_rsp(found, waits);
    accept_rsp(got);
    exp = exp_q.pop_front();
    tests++;
    if (!found || got !== exp || b_tot - b0 != 1) begin
      fails++; $display("[TB] FAIL mid_fresh: got found=%0d %h b=%0d expected 1 %h 1", found, got, b_tot - b0, exp);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_skew();
    test_read_delay();
    test_rsp_stall();
    test_error_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
